ltsm_sb_handshake_tx: RTL and testbench

// - Generic TX-side sideband req/resp handshake engine for LTSM substates (TRAINERROR, LINKERROR, L1/L2 entry, ...).
// - Sends REQ_MSG to the partner, then waits for RESP_MSG. Handles a partner REQ that arrives before ours.
// - Arbitrates the shared SB encoder against the RX-side engine. Applies a per-attempt timeout and a bounded retry count.
// - Sits between the LTSM substate controller and the SB encoder. One instance per handshake type.

---
 rtl/ltsm_sb_handshake_tx.sv | 172 +++++++++++++++++
 tb/tb_ltsm_sb_handshake_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ltsm_sb_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : ltsm_sb_handshake_tx
// Brief    : TX-side sideband REQ/RESP handshake engine with per-attempt
//            timeout, bounded retry and SB encoder arbitration vs. RX engine.
// Revision : 1.0
// ============================================================================
module ltsm_sb_handshake_tx #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int REQ_MSG        = 15,
  parameter int RESP_MSG       = 14,
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int CNT_WIDTH      = 20,
  parameter int MAX_RETRY      = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic                    i_falling_edge_busy,
  input  logic                    i_rx_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx,
  output logic                    o_valid_tx,
  output logic                    o_done,
  output logic                    o_timeout,
  output logic [1:0]              o_retry_cnt
);

  // Wide enough to hold MAX_RETRY plus one, so the compare never wraps.
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  localparam logic [SB_MSG_WIDTH-1:0] c_req_msg   = SB_MSG_WIDTH'(REQ_MSG);
  localparam logic [SB_MSG_WIDTH-1:0] c_resp_msg  = SB_MSG_WIDTH'(RESP_MSG);
  localparam logic [CNT_WIDTH-1:0]    c_timer_exp = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]    c_timer_max = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]    c_timer_one = CNT_WIDTH'(1);
  localparam logic [RETRY_W-1:0]      c_max_retry = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0]      c_retry_one = RETRY_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_RX   = 3'd1,
    ST_SEND_REQ  = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_DONE      = 3'd4,
    ST_TIMEOUT   = 3'd5
  } state_t;

  state_t                    state_q,    state_d;
  logic [CNT_WIDTH-1:0]      timer_q,    timer_d;
  logic [RETRY_W-1:0]        retry_q,    retry_d;
  logic                      valid_q,    valid_d;
  logic                      done_q,     done_d;
  logic                      timeout_q,  timeout_d;
  logic [SB_MSG_WIDTH-1:0]   encoded_q,  encoded_d;
  logic [1:0]                retry_cnt_q, retry_cnt_d;

  logic resp_seen;
  logic timer_expired;

  assign resp_seen     = (i_decoded_SB_msg == c_resp_msg);
  assign timer_expired = (timer_q == c_timer_exp);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;

    if (!i_en) begin
      state_d = ST_IDLE;
      timer_d = '0;
      retry_d = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timer_d = '0;
          retry_d = '0;
          valid_d = 1'b0;
          // A partner REQ already decoded means the RX engine answers first.
          state_d = (i_decoded_SB_msg == c_req_msg) ? ST_WAIT_RX : ST_SEND_REQ;
        end

        ST_WAIT_RX: begin
          valid_d = 1'b0;
          if (i_falling_edge_busy && i_rx_valid) begin
            state_d = ST_SEND_REQ;
          end
        end

        ST_SEND_REQ: begin
          valid_d = 1'b1;
          timer_d = '0;
          state_d = ST_WAIT_RESP;
        end

        ST_WAIT_RESP: begin
          if (timer_q != c_timer_max) begin
            timer_d = timer_q + c_timer_one;
          end
          if (i_falling_edge_busy && !i_rx_valid) begin
            valid_d = 1'b0;
          end
          // RESP takes priority over a same-cycle timer expiry.
          if (resp_seen) begin
            valid_d = 1'b0;
            state_d = ST_DONE;
          end else if (timer_expired) begin
            valid_d = 1'b0;
            if (retry_q < c_max_retry) begin
              retry_d = retry_q + c_retry_one;
              state_d = i_rx_valid ? ST_WAIT_RX : ST_SEND_REQ;
            end else begin
              state_d = ST_TIMEOUT;
            end
          end
        end

        ST_DONE: begin
          valid_d = 1'b0;
          done_d  = 1'b1;
        end

        ST_TIMEOUT: begin
          valid_d   = 1'b0;
          timeout_d = 1'b1;
        end

        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end

    encoded_d   = valid_d ? c_req_msg : '0;
    retry_cnt_d = (int'(retry_d) > 3) ? 2'd3 : 2'(retry_d);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      retry_q     <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      encoded_q   <= '0;
      retry_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      encoded_q   <= encoded_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign o_encoded_SB_msg_tx = encoded_q;
  assign o_valid_tx          = valid_q;
  assign o_done              = done_q;
  assign o_timeout           = timeout_q;
  assign o_retry_cnt         = retry_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ltsm_sb_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ltsm_sb_handshake_tx
// Brief    : Randomized scoreboard bench for ltsm_sb_handshake_tx.
// Revision : 1.0
// ============================================================================
module tb_ltsm_sb_handshake_tx;

  localparam int T    = 16;
  localparam int MR   = 2;
  localparam int CW   = 5;
  localparam int MW   = 4;
  localparam int REQ  = 15;
  localparam int RESP = 14;

  localparam int K_SEND = 0;
  localparam int K_DONE = 1;
  localparam int K_TO   = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_en = 1'b0;
  logic          i_falling_edge_busy = 1'b0;
  logic          i_rx_valid = 1'b0;
  logic [MW-1:0] i_decoded_SB_msg = '0;
  logic [MW-1:0] o_encoded_SB_msg_tx;
  logic          o_valid_tx;
  logic          o_done;
  logic          o_timeout;
  logic [1:0]    o_retry_cnt;

  ltsm_sb_handshake_tx #(
    .SB_MSG_WIDTH   (MW),
    .REQ_MSG        (REQ),
    .RESP_MSG       (RESP),
    .TIMEOUT_CYCLES (T),
    .CNT_WIDTH      (CW),
    .MAX_RETRY      (MR)
  ) u_dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_en                (i_en),
    .i_falling_edge_busy (i_falling_edge_busy),
    .i_rx_valid          (i_rx_valid),
    .i_decoded_SB_msg    (i_decoded_SB_msg),
    .o_encoded_SB_msg_tx (o_encoded_SB_msg_tx),
    .o_valid_tx          (o_valid_tx),
    .o_done              (o_done),
    .o_timeout           (o_timeout),
    .o_retry_cnt         (o_retry_cnt)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int kind;
    int when_e;
    int retry;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input int when_e, input int retry);
    exp_t e;
    e.kind   = kind;
    e.when_e = when_e;
    e.retry  = retry;
    sb_q.push_back(e);
  endtask

  task automatic take(input int kind, input string nm);
    exp_t e;
    total++;
    if (sb_q.size() > 0 && sb_q[0].kind == kind) begin
      e = sb_q.pop_front();
      if (cyc != e.when_e) begin
        bad++;
        $display("FAIL %s_cycle: got %0d, expected %0d", nm, cyc, e.when_e);
      end
      if (kind != K_SEND) check({nm, "_retry_cnt"}, int'(o_retry_cnt), e.retry);
    end else begin
      bad++;
      $display("FAIL %s_unexpected: event at cycle %0d, pending=%0d", nm, cyc, sb_q.size());
    end
  endtask

  // Monitor: pops expected events as the DUT presents them and applies
  // the protocol rules that hold on every cycle.
  initial begin : monitor
    logic pv, pd, pt;
    logic en_s, busy_s, rx_s;
    pv = 1'b0;
    pd = 1'b0;
    pt = 1'b0;
    forever begin
      @(posedge i_clk);
      en_s   = i_en;
      busy_s = i_falling_edge_busy;
      rx_s   = i_rx_valid;
      #1;
      if (!en_s) begin
        check("disabled_valid",   int'(o_valid_tx), 0);
        check("disabled_encoded", int'(o_encoded_SB_msg_tx), 0);
        check("disabled_done",    int'(o_done), 0);
        check("disabled_timeout", int'(o_timeout), 0);
        check("disabled_retry",   int'(o_retry_cnt), 0);
      end else begin
        if (busy_s && !rx_s && pv) check("busy_clears_valid", int'(o_valid_tx), 0);
        if (o_valid_tx && !pv) begin
          check("no_rx_contention", int'(rx_s), 0);
          check("req_code", int'(o_encoded_SB_msg_tx), REQ);
          take(K_SEND, "send");
        end
        if (o_done && !pd) begin
          take(K_DONE, "done");
          check("done_not_timeout", int'(o_timeout), 0);
        end
        if (o_timeout && !pt) begin
          take(K_TO, "timeout");
          check("timeout_not_done", int'(o_done), 0);
        end
      end
      pv = o_valid_tx;
      pd = o_done;
      pt = o_timeout;
    end
  end

  // mode: 0 normal, 1 partner REQ first, 2 abort while valid is high.
  // att : attempt index that receives RESP; MR+1 means never.
  // off : cycles after the REQ appears at which RESP is decoded (1..T).
  task automatic run_episode(input int mode, input int att, input int off);
    int k, b, r, a, last, ev, stop_en, stop, e;
    int s  [MR+1];
    int bd [MR+1];
    k = cyc + 2;
    b = (mode == 1) ? k + int'($urandom_range(2, 6)) : k - 1;
    s[0] = (mode == 1) ? b + 1 : k + 1;
    for (int n = 0; n <= MR; n++) begin
      s[n]  = s[0] + n * (T + 1);
      bd[n] = int'($urandom_range(1, T - 1));
    end
    r    = -1;
    a    = -1;
    last = 0;
    if (mode == 2) begin
      a = s[0] + int'($urandom_range(1, 3));
      push_exp(K_SEND, s[0], 0);
      stop_en = a - 1;
    end else begin
      last = (att <= MR) ? att : MR;
      for (int n = 0; n <= last; n++) push_exp(K_SEND, s[n], 0);
      if (att <= MR) begin
        r  = s[att] + off;
        ev = r + 1;
        push_exp(K_DONE, ev, att);
      end else begin
        ev = s[MR] + T + 1;
        push_exp(K_TO, ev, MR);
      end
      stop_en = ev + 2;
    end
    stop = stop_en + 3;
    e = 0;
    while (e <= stop) begin
      @(negedge i_clk);
      e = cyc + 1;
      i_en                = (e >= k && e <= stop_en);
      i_rx_valid          = (mode == 1 && e >= k && e <= b);
      i_falling_edge_busy = (mode == 1 && e == b);
      if (mode != 2) begin
        for (int n = 0; n <= last; n++) begin
          if (e == s[n] + bd[n]) i_falling_edge_busy = 1'b1;
        end
      end
      i_decoded_SB_msg = ($urandom_range(0, 3) == 0) ? MW'($urandom_range(1, 13)) : '0;
      if (mode == 1 && e == k) i_decoded_SB_msg = MW'(REQ);
      if (e == r)              i_decoded_SB_msg = MW'(RESP);
    end
    check("events_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin : driver
    int mode;
    repeat (3) @(negedge i_clk);
    check("rst_valid",   int'(o_valid_tx), 0);
    check("rst_encoded", int'(o_encoded_SB_msg_tx), 0);
    check("rst_done",    int'(o_done), 0);
    check("rst_timeout", int'(o_timeout), 0);
    check("rst_retry",   int'(o_retry_cnt), 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run_episode(0, 0, 5);        // plain handshake
    run_episode(1, 0, 4);        // partner REQ first
    run_episode(0, MR + 1, 1);   // retries exhausted
    run_episode(0, 1, 7);        // success on second attempt
    run_episode(0, 0, T);        // RESP on the expiry cycle
    run_episode(0, MR, T);       // RESP on the final expiry cycle
    run_episode(2, 0, 0);        // abort mid-send
    run_episode(0, 0, 1);        // clean restart after abort

    for (int i = 0; i < 40; i++) begin
      mode = ($urandom_range(0, 4) == 0) ? 2 : int'($urandom_range(0, 1));
      run_episode(mode, int'($urandom_range(0, MR + 1)), int'($urandom_range(1, T)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
